// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM: CHANNELS outputs share one programmable period counter.
// Button duty steps and period/mode changes are shadowed to the period boundary.
module pwm_lane #(
   parameter int CNT_W     = 8,
   parameter int STEP      = 1,
   parameter int DUTY_INIT = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             boundary,
   input  logic [CNT_W-1:0] pe,
   input  logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] duty,
   output logic             pwm
);
   localparam logic [CNT_W-1:0] STEP_N = CNT_W'(STEP);
   localparam logic [CNT_W:0]   STEP_X = (CNT_W+1)'(STEP);

   logic [CNT_W-1:0] shadow;
   logic [CNT_W:0]   sum;
   logic [CNT_W-1:0] inc_val, dec_val;

   // One extra bit of headroom so increments saturate instead of wrapping.
   assign sum     = {1'b0, shadow} + STEP_X;
   assign inc_val = (sum > {1'b0, pe}) ? pe : sum[CNT_W-1:0];
   assign dec_val = (shadow < STEP_N) ? '0 : shadow - STEP_N;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow <= CNT_W'(DUTY_INIT);
         duty   <= CNT_W'(DUTY_INIT);
         pwm    <= 1'b0;
      end else begin
         if (inc)      shadow <= inc_val;
         else if (dec) shadow <= dec_val;
         if (boundary) duty <= (shadow > pe) ? pe : shadow;
         pwm <= (cnt < duty);
      end
   end
endmodule

module pwm_multi_channel #(
   parameter int CHANNELS    = 4,
   parameter int CNT_W       = 8,
   parameter int DEB_DIV     = 2,
   parameter int STEP        = 1,
   parameter int DUTY_INIT   = 5,
   parameter int PERIOD_INIT = 10,
   localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ui_increase_duty,
   input  logic                ui_decrease_duty,
   input  logic [SEL_W-1:0]    ui_ch_sel,
   input  logic [CNT_W-1:0]    ui_period,
   input  logic                ui_center,
   output logic [CHANNELS-1:0] uo_pwm,
   output logic                uo_period_start,
   output logic [CNT_W-1:0]    uo_duty
);
   localparam int TICK_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

   typedef enum logic {UP, DOWN} dir_t;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              inc_q1, inc_q2, dec_q1, dec_q2;
   logic              press_inc, press_dec, sel_ok, do_inc, do_dec;
   logic [CNT_W-1:0]  pe, per, per_m1, cnt, cnt_nxt, per_nxt;
   logic              center, center_nxt, boundary;
   dir_t              dir, dir_nxt;
   logic [CHANNELS-1:0][CNT_W-1:0] duty_act;

   assign tick = (tick_cnt == TICK_W'(DEB_DIV - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
         inc_q1 <= 1'b0; inc_q2 <= 1'b0;
         dec_q1 <= 1'b0; dec_q2 <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
         if (tick) begin
            inc_q1 <= ui_increase_duty; inc_q2 <= inc_q1;
            dec_q1 <= ui_decrease_duty; dec_q2 <= dec_q1;
         end
      end
   end

   // Rising edge seen across two sample ticks; simultaneous inc+dec cancels.
   assign press_inc = inc_q1 & ~inc_q2 & tick;
   assign press_dec = dec_q1 & ~dec_q2 & tick;
   assign sel_ok    = ({1'b0, ui_ch_sel} < (SEL_W+1)'(CHANNELS));
   assign do_inc    = press_inc & ~press_dec & sel_ok;
   assign do_dec    = press_dec & ~press_inc & sel_ok;

   assign pe     = (ui_period == '0) ? CNT_W'(1) : ui_period;
   assign per_m1 = per - CNT_W'(1);

   always_comb begin
      cnt_nxt    = cnt + CNT_W'(1);
      dir_nxt    = dir;
      per_nxt    = per;
      center_nxt = center;
      boundary   = 1'b0;
      if (center) begin
         // Center mode dwells one extra cycle at each end of the ramp.
         if (dir == UP) begin
            if (cnt == per_m1) begin
               cnt_nxt = cnt;
               dir_nxt = DOWN;
            end
         end else if (cnt == '0) begin
            boundary = 1'b1;
         end else begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end else if (cnt == per_m1) begin
         boundary = 1'b1;
      end
      if (boundary) begin
         cnt_nxt    = '0;
         dir_nxt    = UP;
         per_nxt    = pe;
         center_nxt = ui_center;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt             <= '0;
         dir             <= UP;
         per             <= CNT_W'(PERIOD_INIT);
         center          <= 1'b0;
         uo_period_start <= 1'b0;
      end else begin
         cnt             <= cnt_nxt;
         dir             <= dir_nxt;
         per             <= per_nxt;
         center          <= center_nxt;
         uo_period_start <= (cnt == '0) && (dir == UP);
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      logic hit;
      assign hit = (ui_ch_sel == SEL_W'(i));
      pwm_lane #(.CNT_W(CNT_W), .STEP(STEP), .DUTY_INIT(DUTY_INIT)) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .inc      (do_inc & hit),
         .dec      (do_dec & hit),
         .boundary (boundary),
         .pe       (pe),
         .cnt      (cnt),
         .duty     (duty_act[i]),
         .pwm      (uo_pwm[i])
      );
   end

   assign uo_duty = sel_ok ? duty_act[ui_ch_sel] : '0;
endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: expected waveforms are queued from a
// spec-level model of the output pattern and compared on falling clock edges.
module tb_pwm_multi_channel;
   logic       clk = 1'b0;
   logic       rst_n, inc, dec, center;
   logic [1:0] sel;
   logic [7:0] period;
   logic [3:0] pwm;
   logic       ps;
   logic [7:0] duty;

   always #5 clk = ~clk;

   pwm_multi_channel #(
      .CHANNELS(4), .CNT_W(8), .DEB_DIV(2), .STEP(1), .DUTY_INIT(5), .PERIOD_INIT(10)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ui_increase_duty (inc),
      .ui_decrease_duty (dec),
      .ui_ch_sel        (sel),
      .ui_period        (period),
      .ui_center        (center),
      .uo_pwm           (pwm),
      .uo_period_start  (ps),
      .uo_duty          (duty)
   );

   typedef struct {
      int         k;
      logic [3:0] pwm;
      logic       ps;
      logic [7:0] duty;
   } exp_t;

   exp_t sbq[$];
   int   tduty[4];
   int   tests_run = 0, tests_failed = 0;

   // Expected outputs k cycles after a period start, from the duty each
   // channel should hold (clamped to the period) and the waveform shape.
   function automatic exp_t model(int k, int p, bit ctr, int s);
      exp_t e;
      int len, ph, c, d;
      len = ctr ? 2 * p : p;
      ph  = k % len;
      c   = (ph < p) ? ph : 2 * p - 1 - ph;
      e.k = k;
      e.pwm = '0;
      for (int ch = 0; ch < 4; ch++) begin
         d = (tduty[ch] < p) ? tduty[ch] : p;
         e.pwm[ch] = (c < d);
      end
      e.ps   = (ph == 0);
      e.duty = 8'((tduty[s] < p) ? tduty[s] : p);
      return e;
   endfunction

   task automatic sync_start();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ps !== 1'b1 && n < 64);
      tests_run++;
      if (ps !== 1'b1) begin
         tests_failed++;
         $display("FAIL sync: uo_period_start=%b after 64 cycles, required 1", ps);
      end
   endtask

   task automatic press(bit i, bit d);
      inc = i; dec = d;
      repeat (6) @(negedge clk);
      inc = 1'b0; dec = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inc = 1'b0; dec = 1'b0; sel = 2'd0; period = 8'd10; center = 1'b0;
      for (int ch = 0; ch < 4; ch++) tduty[ch] = 5;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({pwm, ps, duty} !== {4'b0000, 1'b0, 8'd5}) begin
         tests_failed++;
         $display("FAIL reset: pwm=%b ps=%b duty=%0d, required 0000/0/5", pwm, ps, duty);
      end
   endtask

   task automatic test_edge_default();
      exp_t e;
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) sbq.push_back(model(k, 10, 1'b0, 0));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL edge_default k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
   endtask

   task automatic test_hold_inc();
      exp_t e;
      sel = 2'd2;
      sync_start();
      inc = 1'b1;
      for (int k = 1; k <= 8; k++) sbq.push_back(model(k, 10, 1'b0, 2));
      tduty[2] = 6;
      for (int k = 9; k <= 20; k++) sbq.push_back(model(k, 10, 1'b0, 2));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL hold_inc k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
         if (e.k == 20) inc = 1'b0;
      end
      repeat (8) @(negedge clk);
      sync_start();
      for (int k = 1; k <= 20; k++) sbq.push_back(model(k, 10, 1'b0, 2));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL hold_inc_after k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
   endtask

   task automatic test_saturate();
      exp_t e;
      sel = 2'd1;
      for (int phase = 0; phase < 3; phase++) begin
         if (phase == 0) begin
            repeat (7) press(1'b1, 1'b0);
            tduty[1] = 10;
         end else if (phase == 1) begin
            repeat (12) press(1'b0, 1'b1);
            tduty[1] = 0;
         end else begin
            repeat (2) press(1'b1, 1'b0);
            press(1'b1, 1'b1);
            tduty[1] = 2;
         end
         sync_start();
         for (int k = 1; k <= 10; k++) sbq.push_back(model(k, 10, 1'b0, 1));
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            tests_run++;
            if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
               tests_failed++;
               $display("FAIL saturate%0d k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                        phase, e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
            end
         end
      end
   endtask

   task automatic test_center();
      exp_t e;
      sel = 2'd0;
      repeat (2) press(1'b0, 1'b1);
      tduty[0] = 3;
      center = 1'b1;
      sync_start();
      sync_start();
      for (int k = 1; k <= 40; k++) sbq.push_back(model(k, 10, 1'b1, 0));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL center k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
   endtask

   task automatic test_period_change();
      exp_t e;
      center = 1'b0;
      sel = 2'd3;
      sync_start();
      sync_start();
      repeat (3) @(negedge clk);
      period = 8'd4;
      for (int k = 4; k <= 9; k++) begin
         e = model(k, 10, 1'b0, 3);
         if (k == 9) e.duty = 8'd4;
         sbq.push_back(e);
      end
      for (int k = 10; k <= 25; k++) begin
         e = model(k - 10, 4, 1'b0, 3);
         e.k = k;
         sbq.push_back(e);
      end
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL period4 k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
      period = 8'd0;
      sync_start();
      sync_start();
      for (int k = 1; k <= 8; k++) sbq.push_back(model(k, 1, 1'b0, 3));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL period0 k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      period = 8'd10;
      for (int ch = 0; ch < 4; ch++) begin
         sel = 2'(ch);
         while (tduty[ch] < 8) begin
            press(1'b1, 1'b0);
            tduty[ch]++;
         end
      end
      sync_start();
      sync_start();
      for (int k = 1; k <= 5; k++) sbq.push_back(model(k, 10, 1'b0, 3));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL pre_reset k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({pwm, ps, duty} !== {4'b0000, 1'b0, 8'd5}) begin
         tests_failed++;
         $display("FAIL mid_reset: pwm=%b ps=%b duty=%0d, required 0000/0/5", pwm, ps, duty);
      end
      rst_n = 1'b1;
      for (int ch = 0; ch < 4; ch++) tduty[ch] = 5;
      for (int k = 0; k < 20; k++) sbq.push_back(model(k, 10, 1'b0, 3));
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         @(negedge clk);
         tests_run++;
         if ({pwm, ps, duty} !== {e.pwm, e.ps, e.duty}) begin
            tests_failed++;
            $display("FAIL post_reset k=%0d: pwm=%b ps=%b duty=%0d, required %b/%b/%0d",
                     e.k, pwm, ps, duty, e.pwm, e.ps, e.duty);
         end
      end
   endtask

   initial begin
      test_reset();
      test_edge_default();
      test_hold_inc();
      test_saturate();
      test_center();
      test_period_change();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
